// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture block.
//  - cam_state_e : capture FSM states (WAIT_VS, SKIP, FRAME)
//  - default VGA geometry and counter widths used as top-level parameter defaults
//  - RGB565 field widths and the resulting pixel width
//  - cnt_width() : width needed to hold a down-counter starting at n (at least 1)
package cam_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_SKIP    = 2'd1,
    ST_FRAME   = 2'd2
  } cam_state_e;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_X_W         = 10;
  localparam int DEF_Y_W         = 9;
  localparam int DEF_SKIP_FRAMES = 2;

  localparam int BYTE_W  = 8;
  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// cam_byte_packer: pairs sensor bytes into 16-bit RGB565 words.
// Ports:
//  clk, rst   : capture clock, synchronous active-high reset
//  href, data : registered sensor HREF and data byte
//  pix_stb    : high in the cycle the low byte is present (word complete)
//  pix_word   : {held high byte, current byte}, meaningful while pix_stb=1
//  href_fall  : HREF went 1->0 between the previous and current sample
//  odd_err    : HREF fell while a high byte was still waiting for its partner
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              href,
  input  logic [BYTE_W-1:0] data,
  output logic              pix_stb,
  output logic [PIX_W-1:0]  pix_word,
  output logic              href_fall,
  output logic              odd_err
);

  // phase_lo = 1 means the next byte is the low byte of a pixel.
  logic              phase_lo;
  logic              href_d;
  logic [BYTE_W-1:0] hi_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_lo <= 1'b0;
      href_d   <= 1'b0;
      hi_byte  <= '0;
    end else begin
      href_d <= href;
      if (!href) begin
        phase_lo <= 1'b0;
      end else begin
        if (!phase_lo) hi_byte <= data;
        phase_lo <= ~phase_lo;
      end
    end
  end

  assign pix_stb   = href & phase_lo;
  assign pix_word  = {hi_byte, data};
  assign href_fall = href_d & ~href;
  // phase_lo still reflects the last byte of the line during the fall cycle.
  assign odd_err   = href_fall & phase_lo;

endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: captures an 8-bit parallel camera bus (RGB565, high byte
// first) clocked from our own 24 MHz clock and emits coordinate-tagged pixels.
// Ports:
//  CLK_24, RESET       : capture clock, synchronous active-high reset
//  ENABLE              : capture enable, only looked at on VSYNC rising edges
//  CAM_VSYNC/HREF/D    : sensor bus, registered once before use
//  PIX_DATA/X/Y        : pixel and its coordinates, updated only with PIX_VALID
//  PIX_VALID           : one-cycle strobe; there is no backpressure, the
//                        consumer must accept every strobe in the cycle it occurs
//  FRAME_START         : with the strobe of pixel (0,0)
//  LINE_END            : with the strobe of pixel X=H_ACTIVE-1
//  FRAME_DONE          : cycle after the VSYNC rise closing an output frame
//  ERR_GEOM            : sticky geometry error, cleared by FRAME_START
//  FRAME_CNT           : completed output frames, wraps
//  DBG_STATE           : current capture FSM state
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
  input  logic              CLK_24,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [BYTE_W-1:0] CAM_D,
  output logic [PIX_W-1:0]  PIX_DATA,
  output logic              PIX_VALID,
  output logic [X_W-1:0]    PIX_X,
  output logic [Y_W-1:0]    PIX_Y,
  output logic              FRAME_START,
  output logic              LINE_END,
  output logic              FRAME_DONE,
  output logic              ERR_GEOM,
  output logic [7:0]        FRAME_CNT,
  output cam_state_e        DBG_STATE
);

  localparam int SK_W = cnt_width(SKIP_FRAMES);
  localparam logic [SK_W-1:0] SKIP_INIT = SK_W'(SKIP_FRAMES);
  // Counters carry one extra bit so over-long lines/frames never wrap back
  // into the active window.
  localparam logic [X_W:0]   X_LIM   = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0]   X_LAST  = (X_W+1)'(H_ACTIVE - 1);
  localparam logic [Y_W:0]   Y_LIM   = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W+1:0] V_LINES = (Y_W+2)'(V_ACTIVE);

  // Input stage: sensor runs from our clock, a single register is enough.
  logic              vs_r, vs_prev, href_r;
  logic [BYTE_W-1:0] d_r;

  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      vs_r    <= 1'b0;
      vs_prev <= 1'b0;
      href_r  <= 1'b0;
      d_r     <= '0;
    end else begin
      vs_r    <= CAM_VSYNC;
      vs_prev <= vs_r;
      href_r  <= CAM_HREF;
      d_r     <= CAM_D;
    end
  end

  logic vs_rise;
  assign vs_rise = vs_r & ~vs_prev;

  logic             pix_stb, href_fall, odd_err;
  logic [PIX_W-1:0] pix_word;

  cam_byte_packer u_packer (
    .clk      (CLK_24),
    .rst      (RESET),
    .href     (href_r),
    .data     (d_r),
    .pix_stb  (pix_stb),
    .pix_word (pix_word),
    .href_fall(href_fall),
    .odd_err  (odd_err)
  );

  // X = pixels seen so far in this line, Y = non-empty lines closed since vs_rise.
  logic [X_W:0] x_cnt;
  logic [Y_W:0] y_cnt;
  logic         line_closed;

  assign line_closed = href_fall && (x_cnt != '0);

  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (href_fall)
        x_cnt <= '0;
      else if (pix_stb && (x_cnt != '1))
        x_cnt <= x_cnt + (X_W+1)'(1);

      if (vs_rise)
        y_cnt <= '0;
      else if (line_closed && (y_cnt != '1))
        y_cnt <= y_cnt + (Y_W+1)'(1);
    end
  end

  // Line count as seen by a vs_rise: a line closing in the same cycle counts.
  logic [Y_W+1:0] lines_total;
  assign lines_total = {1'b0, y_cnt} + (Y_W+2)'(line_closed);

  // Capture FSM
  cam_state_e      state_q, state_d;
  logic [SK_W-1:0] skip_q, skip_d;
  logic            frame_done_d;

  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      state_q <= ST_WAIT_VS;
      skip_q  <= SKIP_INIT;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    frame_done_d = 1'b0;
    if (vs_rise) begin
      case (state_q)
        ST_WAIT_VS: begin
          if (skip_q != '0)  state_d = ST_SKIP;
          else if (ENABLE)   state_d = ST_FRAME;
        end
        ST_SKIP: begin
          if (skip_q != '0) skip_d = skip_q - SK_W'(1);
          // The frame that just ended was the last one to drop.
          if (skip_q <= SK_W'(1)) state_d = ENABLE ? ST_FRAME : ST_WAIT_VS;
        end
        ST_FRAME: begin
          frame_done_d = 1'b1;
          state_d      = ENABLE ? ST_FRAME : ST_WAIT_VS;
        end
        default: state_d = ST_WAIT_VS;
      endcase
    end
  end

  assign DBG_STATE = state_q;

  // Pixel acceptance and markers
  logic pix_ok, start_d, line_end_d, geom_err;

  assign pix_ok     = pix_stb && (state_q == ST_FRAME) && (x_cnt < X_LIM) && (y_cnt < Y_LIM);
  assign start_d    = pix_ok && (x_cnt == '0) && (y_cnt == '0);
  assign line_end_d = pix_ok && (x_cnt == X_LAST);

  assign geom_err = odd_err
                  | (href_fall && (x_cnt != X_LIM))
                  | (vs_rise && (state_q == ST_FRAME) && (lines_total != V_LINES))
                  | (href_r && vs_r);

  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      PIX_DATA    <= '0;
      PIX_VALID   <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      FRAME_START <= 1'b0;
      LINE_END    <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR_GEOM    <= 1'b0;
      FRAME_CNT   <= '0;
    end else begin
      PIX_VALID   <= pix_ok;
      FRAME_START <= start_d;
      LINE_END    <= line_end_d;
      FRAME_DONE  <= frame_done_d;
      if (pix_ok) begin
        PIX_DATA <= pix_word;
        PIX_X    <= x_cnt[X_W-1:0];
        PIX_Y    <= y_cnt[Y_W-1:0];
      end
      if (frame_done_d) FRAME_CNT <= FRAME_CNT + 8'd1;
      // A new error in the start cycle must survive the clear.
      if (geom_err)     ERR_GEOM <= 1'b1;
      else if (start_d) ERR_GEOM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
module tb_cam_pixel_capture;
  import cam_pkg::*;

  localparam int H    = 6;
  localparam int V    = 4;
  localparam int XW   = 3;
  localparam int YW   = 2;
  localparam int SKIP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, vs = 1'b0, href = 1'b0;
  logic [7:0] d = 8'h00;
  logic       nxt_rst = 1'b1, nxt_en = 1'b0;

  logic [15:0]   pix_data;
  logic          pix_valid, frame_start, line_end, frame_done, err_geom;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [7:0]    frame_cnt;
  cam_state_e    dbg_state;

  cam_pixel_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW), .SKIP_FRAMES(SKIP)
  ) dut (
    .CLK_24(clk), .RESET(rst), .ENABLE(en),
    .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_D(d),
    .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_X(pix_x), .PIX_Y(pix_y),
    .FRAME_START(frame_start), .LINE_END(line_end), .FRAME_DONE(frame_done),
    .ERR_GEOM(err_geom), .FRAME_CNT(frame_cnt), .DBG_STATE(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          v;
    logic [15:0]   d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fs;
    logic          le;
    logic          fd;
    logic          err;
    logic [7:0]    cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int drv_idx = 0, pop_idx = 0, lit_cycle = -1, lit_hits = 0;
  int n_valid = 0, n_le = 0, n_fs = 0, n_fd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the sensor stream by meaning: bytes in the current line, completed
  // lines in the current frame, and whether frames are being skipped, output
  // or ignored. One expected record per clock edge.
  logic       m_reg_vs, m_reg_href, m_prev_vs, m_prev_href;
  logic [7:0] m_reg_d, m_hi;
  int         m_bytes, m_lines, m_mode, m_skip;   // mode: 0 idle, 1 skipping, 2 output
  logic [15:0]   m_data;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic          m_err;
  logic [7:0]    m_cnt;

  task automatic model_reset();
    m_reg_vs = 0; m_reg_href = 0; m_prev_vs = 0; m_prev_href = 0;
    m_reg_d = 0; m_hi = 0; m_bytes = 0; m_lines = 0; m_mode = 0; m_skip = SKIP;
    m_data = 0; m_x = 0; m_y = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input bit h, input logic [7:0] dd);
    exp_t ex;
    bit   rise, fall, set_err;
    int   px;
    ex = '0;
    if (r) begin
      model_reset();
      exp_q.push_back(ex);
      return;
    end
    rise    = m_reg_vs && !m_prev_vs;
    fall    = m_prev_href && !m_reg_href;
    set_err = m_reg_href && m_reg_vs;
    if (m_reg_href) begin
      m_bytes++;
      if (m_bytes % 2 == 1) begin
        m_hi = m_reg_d;
      end else begin
        px = m_bytes / 2 - 1;
        if (m_mode == 2 && px < H && m_lines < V) begin
          ex.v   = 1;
          m_data = {m_hi, m_reg_d};
          m_x    = px[XW-1:0];
          m_y    = m_lines[YW-1:0];
          ex.fs  = (px == 0 && m_lines == 0);
          ex.le  = (px == H - 1);
        end
      end
    end
    if (fall) begin
      if (m_bytes % 2 == 1) set_err = 1;
      if (m_bytes / 2 != H) set_err = 1;
      if (m_bytes >= 2) m_lines++;
      m_bytes = 0;
    end
    if (rise) begin
      if (m_mode == 2) begin
        ex.fd = 1;
        m_cnt = m_cnt + 8'd1;
        if (m_lines != V) set_err = 1;
        m_mode = e ? 2 : 0;
      end else if (m_mode == 1) begin
        m_skip--;
        if (m_skip == 0) m_mode = e ? 2 : 0;
      end else begin
        if (m_skip > 0) m_mode = 1;
        else if (e)     m_mode = 2;
      end
      m_lines = 0;
    end
    if (set_err)    m_err = 1;
    else if (ex.fs) m_err = 0;
    ex.d = m_data; ex.x = m_x; ex.y = m_y; ex.err = m_err; ex.cnt = m_cnt;
    exp_q.push_back(ex);
    m_prev_vs = m_reg_vs; m_prev_href = m_reg_href;
    m_reg_vs = v; m_reg_href = h; m_reg_d = dd;
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("pix_valid",   32'(pix_valid),   32'(ex.v));
        chk("pix_data",    32'(pix_data),    32'(ex.d));
        chk("pix_x",       32'(pix_x),       32'(ex.x));
        chk("pix_y",       32'(pix_y),       32'(ex.y));
        chk("frame_start", 32'(frame_start), 32'(ex.fs));
        chk("line_end",    32'(line_end),    32'(ex.le));
        chk("frame_done",  32'(frame_done),  32'(ex.fd));
        chk("err_geom",    32'(err_geom),    32'(ex.err));
        chk("frame_cnt",   32'(frame_cnt),   32'(ex.cnt));
        if (pix_valid)   n_valid++;
        if (line_end)    n_le++;
        if (frame_start) n_fs++;
        if (frame_done)  n_fd++;
        if (pop_idx == lit_cycle) begin
          lit_hits++;
          chk("lit_valid", 32'(pix_valid),   32'd1);
          chk("lit_data",  32'(pix_data),    32'h0000F81F);
          chk("lit_x",     32'(pix_x),       32'd0);
          chk("lit_y",     32'(pix_y),       32'd0);
          chk("lit_start", 32'(frame_start), 32'd1);
        end
        pop_idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit h, input logic [7:0] dd);
    @(negedge clk);
    rst = nxt_rst; en = nxt_en; vs = v; href = h; d = dd;
    model_step(nxt_rst, nxt_en, v, h, dd);
    drv_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00);
  endtask

  task automatic do_reset();
    nxt_rst = 1; idle(3);
    nxt_rst = 0; idle(2);
  endtask

  task automatic send_line(input int nbytes, input bit fixed_first);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      if (fixed_first && i == 0) b = 8'hF8;
      if (fixed_first && i == 1) begin
        b = 8'h1F;
        lit_cycle = drv_idx + 1;
      end
      drive(0, 1, b);
    end
    idle($urandom_range(2, 4));
  endtask

  task automatic send_vsync(input bit stray);
    idle(1);
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    if (stray) drive(1, 1, 8'($urandom_range(0, 255)));
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    idle(3);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_bytes,
                            input int en_drop, input bit fixed);
    for (int l = 0; l < nlines; l++) begin
      if (l == en_drop) nxt_en = 0;
      send_line((l == bad_line) ? bad_bytes : 2 * H, fixed && (l == 0));
    end
  endtask

  // ---------------- test sequence ----------------
  int v0, fd0;

  initial begin
    model_reset();
    do_reset();
    chk("reset_state", 32'(dbg_state), 32'(ST_WAIT_VS));
    chk("reset_cnt",   32'(frame_cnt), 32'd0);

    // Start-up skip, then one output frame whose first pixel is F8,1F
    nxt_en = 1;
    send_vsync(0); send_frame(V, -1, 0, -1, 0);
    send_vsync(0); send_frame(V, -1, 0, -1, 0);
    send_vsync(0);
    chk("skip_no_valid", 32'(n_valid), 32'd0);
    n_valid = 0; n_le = 0; n_fs = 0; n_fd = 0;
    send_frame(V, -1, 0, -1, 1);
    send_vsync(0);
    chk("t1_strobes",    32'(n_valid),   32'(H * V));
    chk("t1_line_end",   32'(n_le),      32'(V));
    chk("t1_frame_start",32'(n_fs),      32'd1);
    chk("t1_frame_done", 32'(n_fd),      32'd1);
    chk("t1_frame_cnt",  32'(frame_cnt), 32'd1);
    chk("t1_err",        32'(err_geom),  32'd0);
    chk("t2_lit_seen",   32'(lit_hits),  32'd1);

    // Over-long odd line: full line of pixels, error, cleared by next frame
    v0 = n_valid;
    send_frame(V, 1, 2 * H + 1, -1, 0);
    chk("t3_strobes", 32'(n_valid - v0), 32'(H * V));
    chk("t3_err_set", 32'(err_geom), 32'd1);
    send_vsync(0);
    send_frame(V, -1, 0, -1, 0);
    chk("t3_err_clear", 32'(err_geom), 32'd0);
    send_vsync(0);

    // Short frame: error at the closing VSYNC, FRAME_DONE still pulses
    send_frame(V - 1, -1, 0, -1, 0);
    chk("t4_err_before", 32'(err_geom), 32'd0);
    fd0 = n_fd;
    send_vsync(0);
    chk("t4_err_after", 32'(err_geom), 32'd1);
    chk("t4_done",      32'(n_fd - fd0), 32'd1);

    // ENABLE dropped mid-frame: that frame completes, later frames ignored
    v0 = n_valid;
    send_frame(V, -1, 0, 2, 0);
    send_vsync(0);
    chk("t5_full_frame", 32'(n_valid - v0), 32'(H * V));
    v0 = n_valid;
    send_frame(V, -1, 0, -1, 0);
    send_vsync(0);
    nxt_en = 1;
    send_frame(V, -1, 0, -1, 0);
    chk("t5_ignored", 32'(n_valid - v0), 32'd0);
    send_vsync(0);
    send_frame(V, -1, 0, -1, 0);
    chk("t5_resumed", 32'(n_valid - v0), 32'(H * V));
    send_vsync(0);

    // Reset in the middle of an output frame
    send_frame(2, -1, 0, -1, 0);
    fd0 = n_fd;
    do_reset();
    chk("t6_cnt",   32'(frame_cnt), 32'd0);
    chk("t6_valid", 32'(pix_valid), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'(ST_WAIT_VS));
    send_frame(2, -1, 0, -1, 0);
    send_vsync(0);
    chk("t6_no_done", 32'(n_fd - fd0), 32'd0);
    v0 = n_valid;
    send_frame(V, -1, 0, -1, 0); send_vsync(0);
    send_frame(V, -1, 0, -1, 0); send_vsync(0);
    chk("t6_skipped", 32'(n_valid - v0), 32'd0);
    send_frame(V, -1, 0, -1, 0); send_vsync(0);
    chk("t6_cnt_after", 32'(frame_cnt), 32'd1);

    // Randomized frames: geometry faults, enable toggles, stray bytes in VSYNC
    for (int f = 0; f < 14; f++) begin
      int nl, bl, bb, ed;
      int bad_len[4];
      bad_len[0] = 2 * H - 2; bad_len[1] = 2 * H - 1;
      bad_len[2] = 2 * H + 1; bad_len[3] = 2 * H + 2;
      nxt_en = ($urandom_range(0, 3) != 0);
      nl = ($urandom_range(0, 3) == 0) ? V - 1 + 2 * $urandom_range(0, 1) : V;
      bl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, V - 1) : -1;
      bb = bad_len[$urandom_range(0, 3)];
      ed = ($urandom_range(0, 3) == 0) ? $urandom_range(0, V - 1) : -1;
      send_frame(nl, bl, bb, ed, 0);
      send_vsync($urandom_range(0, 4) == 0);
    end

    idle(3);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
